// File: rtl/cu_chan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cu_chan_ctrl_pkg
// Description : Shared types and constants for the channel control unit:
//               the control FSM state encoding and the response codes
//               reported on o_resp_code.
// Revision    : 1.0 - initial release
// ============================================================================
package cu_chan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] RESP_OK          = 2'b00;
  localparam logic [1:0] RESP_ILLEGAL_SEL = 2'b01;
  localparam logic [1:0] RESP_ABORT       = 2'b10;
  localparam logic [1:0] RESP_TIMEOUT     = 2'b11;

endpackage : cu_chan_ctrl_pkg
`default_nettype wire

// File: rtl/cu_onehot_dec.sv
`default_nettype none
// ============================================================================
// Module      : cu_onehot_dec
// Description : Enable-gated binary-to-one-hot decoder. A select value that
//               has no matching channel (i_sel >= NCH) yields all zeros.
// Ports       : i_sel    - binary channel select
//               i_en     - decoder enable; all outputs low when deasserted
//               o_onehot - one-hot channel vector
// Revision    : 1.0 - initial release
// ============================================================================
module cu_onehot_dec #(
  parameter int NCH  = 4,
  parameter int SELW = 2
) (
  input  logic [SELW-1:0] i_sel,
  input  logic            i_en,
  output logic [NCH-1:0]  o_onehot
);

  // Only indices 0..NCH-1 are decoded, so an out-of-range select simply
  // matches nothing and no explicit range comparison is required.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_dec
    assign o_onehot[gi] = i_en && (i_sel == SELW'(gi));
  end

endmodule : cu_onehot_dec
`default_nettype wire

// File: rtl/cu_chan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cu_chan_ctrl
// Description : Sequential multi-channel control unit. Accepts a transfer
//               request for one of NCH channels, drives a one-hot channel
//               enable, counts ready beats on the selected channel and ends
//               with a one-cycle done pulse plus a response code.
// Ports       : clk, rst_n        - clock, synchronous active-low reset
//               i_req_valid/o_req_ready, i_req_sel, i_req_len - request
//               i_abort           - cancel the transfer in progress
//               i_chan_rdy        - per-channel ready
//               o_chan_en         - one-hot enable (XFER only)
//               o_busy, o_done, o_resp_code, o_beats_done - status
// Config      : `define CU_CHAN_CTRL_TIMEOUT_EN builds the stall counter and
//               the TIMEOUT abort; otherwise XFER waits indefinitely.
// Revision    : 1.0 - initial release
// ============================================================================
module cu_chan_ctrl
  import cu_chan_ctrl_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int SELW    = (NCH > 1) ? $clog2(NCH) : 1,
  parameter int LENW    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [SELW-1:0] i_req_sel,
  input  logic [LENW-1:0] i_req_len,
  input  logic            i_abort,
  input  logic [NCH-1:0]  i_chan_rdy,
  output logic [NCH-1:0]  o_chan_en,
  output logic            o_busy,
  output logic            o_done,
  output logic [1:0]      o_resp_code,
  output logic [LENW:0]   o_beats_done
);

  localparam logic [LENW:0] c_BEAT_ONE = (LENW+1)'(1);

  state_t          r_state, w_state_nxt;
  logic [SELW-1:0] r_sel;
  logic [LENW-1:0] r_len;
  logic [LENW:0]   r_beats, w_beats_nxt;
  logic [1:0]      r_code, w_code_nxt;

  logic            w_accept;
  logic            w_sel_ok;
  logic            w_in_xfer;
  logic            w_beat;
  logic            w_last_beat;
  logic            w_stall_hit;
  logic [NCH-1:0]  w_chan_en;

  assign w_accept  = i_req_valid && (r_state == ST_IDLE);
  assign w_sel_ok  = (int'(i_req_sel) < NCH);
  assign w_in_xfer = (r_state == ST_XFER);

  cu_onehot_dec #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_dec (
    .i_sel    (r_sel),
    .i_en     (w_in_xfer),
    .o_onehot (w_chan_en)
  );

  // Masking with the enable vector selects the active channel's ready and
  // ignores every other channel; it is zero outside XFER.
  assign w_beat      = |(i_chan_rdy & w_chan_en);
  assign w_last_beat = w_beat && (r_beats == {1'b0, r_len});

`ifdef CU_CHAN_CTRL_TIMEOUT_EN
  localparam int STW = $clog2(TIMEOUT + 1);
  localparam logic [STW-1:0] c_STALL_ONE  = STW'(1);
  localparam logic [STW-1:0] c_STALL_LAST = STW'(TIMEOUT - 1);

  logic [STW-1:0] r_stall, w_stall_nxt;

  // The current stall cycle is the TIMEOUT-th one when the counter already
  // holds TIMEOUT-1.
  assign w_stall_hit = w_in_xfer && !w_beat && (r_stall == c_STALL_LAST);

  always_comb begin
    w_stall_nxt = r_stall;
    if (w_accept) begin
      w_stall_nxt = '0;
    end else if (w_in_xfer) begin
      w_stall_nxt = w_beat ? '0 : (r_stall + c_STALL_ONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall <= '0;
    end else begin
      r_stall <= w_stall_nxt;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);
  assign w_stall_hit      = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_beats_nxt = r_beats;
    w_code_nxt  = r_code;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_beats_nxt = '0;
          if (w_sel_ok) begin
            w_state_nxt = ST_XFER;
          end else begin
            w_state_nxt = ST_RESP;
            w_code_nxt  = RESP_ILLEGAL_SEL;
          end
        end
      end
      ST_XFER: begin
        if (w_beat) begin
          w_beats_nxt = r_beats + c_BEAT_ONE;
        end
        // Abort wins over completion; a beat in the abort cycle still counts.
        if (i_abort) begin
          w_state_nxt = ST_RESP;
          w_code_nxt  = RESP_ABORT;
        end else if (w_last_beat) begin
          w_state_nxt = ST_RESP;
          w_code_nxt  = RESP_OK;
        end else if (w_stall_hit) begin
          w_state_nxt = ST_RESP;
          w_code_nxt  = RESP_TIMEOUT;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_len   <= '0;
      r_beats <= '0;
      r_code  <= RESP_OK;
    end else begin
      r_state <= w_state_nxt;
      r_beats <= w_beats_nxt;
      r_code  <= w_code_nxt;
      if (w_accept) begin
        r_sel <= i_req_sel;
        r_len <= i_req_len;
      end
    end
  end

  // Every output is decoded from registered state only.
  assign o_req_ready  = (r_state == ST_IDLE);
  assign o_busy       = (r_state != ST_IDLE);
  assign o_done       = (r_state == ST_RESP);
  assign o_chan_en    = w_chan_en;
  assign o_resp_code  = r_code;
  assign o_beats_done = r_beats;

endmodule : cu_chan_ctrl
`default_nettype wire

// File: tb/tb_cu_chan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cu_chan_ctrl
// Description : Self-checking bench for cu_chan_ctrl. A table of transfers
//               is replayed against a 4-channel instance with a response
//               scoreboard; hand-written sequences cover illegal select
//               (3-channel instance), stall behaviour, reset mid-transfer
//               and back-to-back requests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cu_chan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_sel;
  logic [3:0] req_len;
  logic       abort;
  logic [3:0] chan_rdy;
  logic [3:0] chan_en;
  logic       busy;
  logic       done;
  logic [1:0] resp_code;
  logic [4:0] beats_done;

  logic       b_valid;
  logic       b_ready;
  logic [1:0] b_sel;
  logic [3:0] b_len;
  logic       b_abort;
  logic [2:0] b_rdy;
  logic [2:0] b_en;
  logic       b_busy;
  logic       b_done;
  logic [1:0] b_code;
  logic [4:0] b_beats;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] len;
    logic [3:0] rdy_a;
    logic [3:0] rdy_b;
    int         abort_cyc;
    logic [1:0] code;
    logic [4:0] beats;
    int         en_cycles;
  } vec_t;

  typedef struct packed {
    logic [1:0] code;
    logic [4:0] beats;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  exp_t mon_e;

  cu_chan_ctrl #(.NCH(4), .LENW(4), .TIMEOUT(15)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_sel    (req_sel),
    .i_req_len    (req_len),
    .i_abort      (abort),
    .i_chan_rdy   (chan_rdy),
    .o_chan_en    (chan_en),
    .o_busy       (busy),
    .o_done       (done),
    .o_resp_code  (resp_code),
    .o_beats_done (beats_done)
  );

  cu_chan_ctrl #(.NCH(3), .LENW(4), .TIMEOUT(15)) u_dut3 (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req_valid  (b_valid),
    .o_req_ready  (b_ready),
    .i_req_sel    (b_sel),
    .i_req_len    (b_len),
    .i_abort      (b_abort),
    .i_chan_rdy   (b_rdy),
    .o_chan_en    (b_en),
    .o_busy       (b_busy),
    .o_done       (b_done),
    .o_resp_code  (b_code),
    .o_beats_done (b_beats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Scoreboard: every done pulse on the 4-channel instance is matched
  // against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done code=%0d beats=%0d", resp_code, beats_done);
      end else begin
        mon_e = sb_q.pop_front();
        if (resp_code !== mon_e.code || beats_done !== mon_e.beats) begin
          errors++;
          $display("FAIL resp got code=%0d beats=%0d expected code=%0d beats=%0d",
                   resp_code, beats_done, mon_e.code, mon_e.beats);
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int         cyc;
    int         en_cnt;
    int         bad;
    logic       got_done;
    logic [3:0] exp_oh;
    exp_oh = 4'b0001 << v.sel;
    @(posedge clk); #1;
    req_valid = 1'b1; req_sel = v.sel; req_len = v.len; chan_rdy = 4'b0; abort = 1'b0;
    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    sb_q.push_back('{code: v.code, beats: v.beats});
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 0; en_cnt = 0; bad = 0; got_done = 1'b0;
    chan_rdy = v.rdy_a;
    abort = (v.abort_cyc == 0);
    while (!got_done && cyc < 200) begin
      @(negedge clk);
      if (done) got_done = 1'b1;
      else if (chan_en == exp_oh) en_cnt++;
      else bad++;
      @(posedge clk); #1;
      cyc++;
      chan_rdy = (cyc % 2 == 0) ? v.rdy_a : v.rdy_b;
      abort = (cyc == v.abort_cyc);
    end
    abort = 1'b0; chan_rdy = 4'b0;
    chk("done_seen", {31'b0, got_done}, 32'd1);
    chk("en_cycles", en_cnt, v.en_cycles);
    chk("en_onehot_bad", bad, 0);
    @(negedge clk);
    chk("req_ready_after", {31'b0, req_ready}, 32'd1);
    chk("busy_after", {31'b0, busy}, 32'd0);
  endtask

  initial begin : main
    int   cnt;
    logic seen;
    logic rr[9];
    int   rises[$];

    rst_n = 1'b0; req_valid = 1'b0; req_sel = '0; req_len = '0; abort = 1'b0; chan_rdy = '0;
    b_valid = 1'b0; b_sel = '0; b_len = '0; b_abort = 1'b0; b_rdy = '0;

    //            sel   len    rdy_a    rdy_b    abort code   beats en
    vecs.push_back('{2'd2, 4'd3,  4'b0100, 4'b0100, -1, 2'b00, 5'd4,  4});
    vecs.push_back('{2'd1, 4'd7,  4'b0010, 4'b0000,  4, 2'b10, 5'd3,  5});
    vecs.push_back('{2'd0, 4'd0,  4'b0001, 4'b0001, -1, 2'b00, 5'd1,  1});
    vecs.push_back('{2'd3, 4'd15, 4'b1000, 4'b1000, -1, 2'b00, 5'd16, 16});
    vecs.push_back('{2'd0, 4'd1,  4'b0001, 4'b0001,  1, 2'b10, 5'd2,  2});
    vecs.push_back('{2'd2, 4'd2,  4'b0000, 4'b0000,  0, 2'b10, 5'd0,  1});
    vecs.push_back('{2'd0, 4'd3,  4'b1110, 4'b1110, 10, 2'b10, 5'd0,  11});
    vecs.push_back('{2'd1, 4'd2,  4'b0010, 4'b1101, -1, 2'b00, 5'd3,  5});
`ifdef CU_CHAN_CTRL_TIMEOUT_EN
    vecs.push_back('{2'd0, 4'd3,  4'b0000, 4'b0000, -1, 2'b11, 5'd0,  15});
    vecs.push_back('{2'd0, 4'd3,  4'b1110, 4'b1110, -1, 2'b11, 5'd0,  15});
`endif

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_chan_en", {28'b0, chan_en}, 32'd0);
    chk("rst_resp_code", {30'b0, resp_code}, 32'd0);
    chk("rst_beats_done", {27'b0, beats_done}, 32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Illegal select on the 3-channel instance.
    @(posedge clk); #1;
    b_valid = 1'b1; b_sel = 2'd3; b_len = 4'd5; b_rdy = 3'b111;
    @(negedge clk);
    chk("ill_ready", {31'b0, b_ready}, 32'd1);
    @(posedge clk); #1 b_valid = 1'b0;
    @(negedge clk);
    chk("ill_done", {31'b0, b_done}, 32'd1);
    chk("ill_code", {30'b0, b_code}, 32'd1);
    chk("ill_beats", {27'b0, b_beats}, 32'd0);
    chk("ill_en", {29'b0, b_en}, 32'd0);
    @(negedge clk);
    chk("ill_done_pulse", {31'b0, b_done}, 32'd0);
    chk("ill_ready_again", {31'b0, b_ready}, 32'd1);
    // Highest legal channel on the same instance.
    @(posedge clk); #1;
    b_valid = 1'b1; b_sel = 2'd2; b_len = 4'd0;
    @(posedge clk); #1 b_valid = 1'b0;
    @(negedge clk);
    chk("dut3_en", {29'b0, b_en}, 32'd4);
    @(negedge clk);
    chk("dut3_done", {31'b0, b_done}, 32'd1);
    chk("dut3_code", {30'b0, b_code}, 32'd0);
    chk("dut3_beats", {27'b0, b_beats}, 32'd1);
    b_rdy = 3'b000;

`ifndef CU_CHAN_CTRL_TIMEOUT_EN
    // Without the timeout, a stalled transfer waits; ready on other
    // channels does not count.
    @(posedge clk); #1;
    req_valid = 1'b1; req_sel = 2'd0; req_len = 4'd3; chan_rdy = 4'b1110;
    @(posedge clk); #1 req_valid = 1'b0;
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("stall_no_done", cnt, 0);
    chk("stall_en_held", {28'b0, chan_en}, 32'd1);
    sb_q.push_back('{code: 2'b00, beats: 5'd4});
    @(posedge clk); #1 chan_rdy = 4'b0001;
    seen = 1'b0; cnt = 0;
    while (!seen && cnt < 20) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      cnt++;
    end
    chk("stall_release_done", {31'b0, seen}, 32'd1);
    chk("stall_release_cycles", cnt, 5);
    @(posedge clk); #1 chan_rdy = 4'b0;
`endif

    // Reset in the middle of a transfer.
    @(posedge clk); #1;
    req_valid = 1'b1; req_sel = 2'd1; req_len = 4'd15; chan_rdy = 4'b0010;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0; req_valid = 1'b1; req_sel = 2'd0; req_len = 4'd0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_chan_en", {28'b0, chan_en}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_ready", {31'b0, req_ready}, 32'd1);
    chk("mid_rst_done", {31'b0, done}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_ignores_valid", {31'b0, busy}, 32'd0);

    // Back-to-back len=0 requests.
    @(posedge clk); #1;
    rst_n = 1'b1; chan_rdy = 4'b0001;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      rr[i] = req_ready;
      if (req_ready && req_valid) sb_q.push_back('{code: 2'b00, beats: 5'd1});
      if (req_ready && (i == 0 || !rr[i-1])) rises.push_back(i);
      if (i < 8) @(posedge clk);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; chan_rdy = 4'b0;
    chk("b2b_rises", rises.size(), 3);
    if (rises.size() == 3) begin
      chk("b2b_spacing_1", rises[1] - rises[0], 3);
      chk("b2b_spacing_2", rises[2] - rises[1], 3);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_cu_chan_ctrl
`default_nettype wire

// File: doc/cu_chan_ctrl.md
# cu_chan_ctrl

Parametrised sequential channel control unit. It accepts a transfer request that targets one of NCH channels, drives a one-hot channel enable, and counts handshake beats against that channel's ready line. It finishes with a one-cycle completion pulse and a response code. It is the clocked, multi-channel successor to the combinational 2-bit-select control decoder, and it sits between the command front end and the per-channel datapaths.

## Interface
- NCH, 4: number of channels, 2..16
- SELW, $clog2(NCH) (minimum 1): select width
- LENW, 4: length field width; beats = req_len + 1
- TIMEOUT, 15: number of consecutive stall cycles before timeout abort, at least 1
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request offered
- req_ready  out  1  request accepted when both valid and ready are high
- req_sel  in  SELW  target channel
- req_len  in  LENW  beat count minus 1
- abort  in  1  cancels the transfer in progress
- chan_rdy  in  NCH  per-channel ready
- chan_en  out  NCH  one-hot enable; all zeros outside XFER
- busy  out  1  high in XFER and RESP
- done  out  1  one-cycle completion pulse
- resp_code  out  2  00 OK, 01 ILLEGAL_SEL, 10 ABORT, 11 TIMEOUT; valid while done is high
- beats_done  out  LENW+1  beats completed; valid while done is high

## Operation
- States: IDLE, XFER, RESP.
- IDLE:
  - req_ready = 1.
  - On accept, latch req_sel and req_len, and clear the beat counter and stall counter.
  - If req_sel >= NCH, go to RESP with ILLEGAL_SEL and beats_done = 0. Otherwise go to XFER.
- XFER:
  - chan_en[sel] = 1.
  - A beat is a cycle where chan_rdy[sel] is high. Each beat increments the beat counter and clears the stall counter.
  - A stall is a cycle where chan_rdy[sel] is low. Each stall increments the stall counter.
- XFER exit priority, evaluated every cycle:
  - abort → RESP/ABORT. A beat in that same cycle is still counted.
  - Final beat (count reaches req_len + 1) → RESP/OK.
  - Stall counter reaches TIMEOUT → RESP/TIMEOUT.
- RESP: done = 1 for exactly one cycle, then IDLE.
- chan_rdy of channels other than sel are ignored.
- abort is ignored in IDLE and RESP.
- The beat counter is LENW+1 bits wide and never wraps, because the maximum count is 2^LENW.
- Synchronous reset in any state:
  - Next state is IDLE and all counters are cleared.
  - chan_en, busy and done go to 0; resp_code and beats_done go to 0; req_ready goes to 1.
  - An in-flight transfer is dropped without a done pulse.
  - req_valid is ignored while rst_n is low.

## Timing
- Request accepted at edge T.
- chan_en is asserted from T+1.
- Final beat sampled at edge T+k: chan_en drops and done is high during cycle T+k+1.
- req_ready is high again from T+k+2.
- Minimum request-to-request spacing is 3 cycles (len = 0, ready always high).
- ILLEGAL_SEL: done is high in cycle T+1 and chan_en is never asserted.
- All outputs are decoded from registered state and counters. There is no combinational path from any input to any output.

## Configuration
- CU_CHAN_CTRL_TIMEOUT_EN
  - Defined: the stall counter ($clog2(TIMEOUT+1) bits) and the TIMEOUT exit are built.
  - Undefined: the stall counter is removed, XFER waits indefinitely, code 11 is never produced, and the TIMEOUT parameter is unused.

## Structure
- Package cu_chan_ctrl_pkg holds:
  - the state enum (IDLE, XFER, RESP);
  - the resp_code localparams (RESP_OK, RESP_ILLEGAL_SEL, RESP_ABORT, RESP_TIMEOUT).
- Sub-module cu_onehot_dec (parameters NCH and SELW): inputs sel and en; output onehot, which is all zeros when en is low or sel >= NCH. It generates chan_en.

## Test plan
- NCH=4, sel=2, len=3, chan_rdy=4'b0100 constant → chan_en=4'b0100 for 4 cycles; then done=1, resp_code=00, beats_done=4.
- NCH=3, sel=3 → done at T+1, resp_code=01, beats_done=0, chan_en stays 0.
- sel=1, len=7, ready toggling 1010…, abort on the third ready cycle → resp_code=10, beats_done=3.
- With CU_CHAN_CTRL_TIMEOUT_EN and TIMEOUT=15, sel=0 with chan_rdy[0]=0 → done exactly 15 XFER cycles after chan_en rises, resp_code=11. Repeat without the macro and hold ready low for 100 cycles → no done; raising ready then completes the transfer with OK.
- Ready on the wrong channel only (sel=0, chan_rdy=4'b1110) → no beats are counted.
- Assert rst_n=0 mid-XFER → next cycle chan_en=0, busy=0, req_ready=1, no done. Then a back-to-back len=0 request pair shows req_ready rising 3 cycles apart.
